// File: rtl/sos_pkg.sv
// Shared types and default constants for the SOS ultrasonic ranging blocks
// (impulse transmitter and distance calculator).
package sos_pkg;

   // Transmitter sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GUARD = 2'd2
   } sos_state_e;

   localparam int                 DEF_BURST_LEN = 8;
   localparam int                 DEF_GUARD_LEN = 64;
   localparam logic signed [15:0] DEF_AMPLITUDE = 16'sd16000;

endpackage

// File: rtl/sos_impulse_tx.sv
// Square-wave burst generator for the ranging speaker path.
// A burst of BURST_LEN tapered square-wave samples is emitted on request,
// followed by GUARD_LEN silent samples before the block re-arms.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | silent, waiting for a sample strobe with impulse_in high
// ST_BURST | emitting burst samples, k_cnt is the index on amp_out
// ST_GUARD | silent hold-off, g_cnt counts strobes since the burst ended
module sos_impulse_tx
   import sos_pkg::*;
#(
   parameter int                 BURST_LEN   = DEF_BURST_LEN,
   parameter int                 HALF_PERIOD = 1,
   parameter logic signed [15:0] AMPLITUDE   = DEF_AMPLITUDE,
   parameter int                 GUARD_LEN   = DEF_GUARD_LEN
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               step_in,
   input  logic               impulse_in,
   output logic signed [15:0] amp_out,
   output logic               impulse_out,
   output logic               busy_out,
   output logic               done_out
);

   localparam int K_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int G_W = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(BURST_LEN - 1);
   localparam logic [G_W-1:0] G_LAST = G_W'(GUARD_LEN - 1);

   sos_state_e         state;
   logic [K_W-1:0]     k_cnt;
   logic [G_W-1:0]     g_cnt;

   logic [K_W-1:0]     smp_idx;
   logic signed [15:0] smp_mag;
   logic               smp_neg;
   logic signed [15:0] smp_val;

   // Shape the sample that the next strobe will load: index 0 when starting
   // from idle, otherwise the one after the sample currently on amp_out.
   // First and last samples are halved to soften the burst edges.
   always_comb begin
      smp_idx = '0;
      if (state == ST_BURST) begin
         smp_idx = k_cnt + 1'b1;
      end
      smp_mag = AMPLITUDE;
      if ((smp_idx == '0) || (smp_idx == K_LAST)) begin
         smp_mag = AMPLITUDE >>> 1;
      end
      smp_neg = ((int'(smp_idx) / HALF_PERIOD) % 2) != 0;
      smp_val = smp_neg ? -smp_mag : smp_mag;
   end

   // Sequencer: state, counters and all outputs advance only on sample strobes;
   // the pulse outputs drop back after a single clock.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= ST_IDLE;
         k_cnt       <= '0;
         g_cnt       <= '0;
         amp_out     <= '0;
         impulse_out <= 1'b0;
         busy_out    <= 1'b0;
         done_out    <= 1'b0;
      end else begin
         impulse_out <= 1'b0;
         done_out    <= 1'b0;
         if (step_in) begin
            case (state)
               ST_IDLE: begin
                  if (impulse_in) begin
                     state       <= ST_BURST;
                     k_cnt       <= '0;
                     amp_out     <= smp_val;
                     impulse_out <= 1'b1;
                     busy_out    <= 1'b1;
                  end else begin
                     amp_out <= '0;
                  end
               end
               ST_BURST: begin
                  if (k_cnt == K_LAST) begin
                     state   <= ST_GUARD;
                     k_cnt   <= '0;
                     g_cnt   <= '0;
                     amp_out <= '0;
                  end else begin
                     k_cnt   <= k_cnt + 1'b1;
                     amp_out <= smp_val;
                  end
               end
               ST_GUARD: begin
                  if (g_cnt == G_LAST) begin
                     state    <= ST_IDLE;
                     g_cnt    <= '0;
                     done_out <= 1'b1;
                     busy_out <= 1'b0;
                  end else begin
                     g_cnt <= g_cnt + 1'b1;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  k_cnt    <= '0;
                  g_cnt    <= '0;
                  amp_out  <= '0;
                  busy_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sos_impulse_tx.sv
// Bench for sos_impulse_tx: two instances (HALF_PERIOD 1 and 2) share the
// stimulus. A step-timeline model predicts every output each clock; literal
// sequences and step distances pin the model.
module tb_sos_impulse_tx;

   localparam int BL  = 8;
   localparam int GL  = 64;
   localparam int AMP = 16000;

   logic               clk_in = 1'b0;
   logic               rst_in = 1'b0;
   logic               step_in = 1'b0;
   logic               impulse_in = 1'b0;
   logic signed [15:0] amp_a, amp_b;
   logic               imp_a, imp_b, busy_a, busy_b, done_a, done_b;

   int checks = 0;
   int errors = 0;

   sos_impulse_tx dut_a (
      .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .impulse_in(impulse_in),
      .amp_out(amp_a), .impulse_out(imp_a), .busy_out(busy_a), .done_out(done_a));

   sos_impulse_tx #(.HALF_PERIOD(2)) dut_b (
      .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .impulse_in(impulse_in),
      .amp_out(amp_b), .impulse_out(imp_b), .busy_out(busy_b), .done_out(done_b));

   always #5 clk_in = ~clk_in;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 40)
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Burst sample k at a given half-period, straight from the waveform rules.
   function automatic int exp_sample(input int k, input int hp);
      int mag;
      mag = (k == 0 || k == BL - 1) ? AMP / 2 : AMP;
      return (((k / hp) % 2) == 1) ? -mag : mag;
   endfunction

   // Model: position in the burst+guard timeline, counted in strobes.
   int  m_pos = -1;
   bit  m_imp = 0, m_done = 0, m_stepped = 0;
   int  m_amp_a = 0, m_amp_b = 0;
   int  step_no = 0;

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         m_pos = -1; m_imp = 0; m_done = 0; m_stepped = 0;
         m_amp_a = 0; m_amp_b = 0;
      end else begin
         m_imp = 0; m_done = 0; m_stepped = 0;
         if (step_in) begin
            m_stepped = 1;
            step_no++;
            if (m_pos < 0) begin
               if (impulse_in) begin
                  m_pos = 0;
                  m_imp = 1;
               end
            end else begin
               m_pos++;
               if (m_pos == BL + GL) begin
                  m_pos  = -1;
                  m_done = 1;
               end
            end
            m_amp_a = (m_pos >= 0 && m_pos < BL) ? exp_sample(m_pos, 1) : 0;
            m_amp_b = (m_pos >= 0 && m_pos < BL) ? exp_sample(m_pos, 2) : 0;
         end
      end
   end

   int amp_log_a[$];
   int amp_log_b[$];
   int imp_q[$];
   int done_q[$];

   // Per-cycle compare against the model plus event logging.
   always @(negedge clk_in) begin
      chk("amp_a", amp_a, m_amp_a);
      chk("amp_b", amp_b, m_amp_b);
      chk("busy_a", busy_a, (m_pos >= 0) ? 1 : 0);
      chk("busy_b", busy_b, (m_pos >= 0) ? 1 : 0);
      chk("impulse_a", imp_a, m_imp ? 1 : 0);
      chk("impulse_b", imp_b, m_imp ? 1 : 0);
      chk("done_a", done_a, m_done ? 1 : 0);
      chk("done_b", done_b, m_done ? 1 : 0);
      if (m_stepped) begin
         amp_log_a.push_back(int'(amp_a));
         amp_log_b.push_back(int'(amp_b));
      end
      if (imp_a === 1'b1) imp_q.push_back(step_no);
      if (done_a === 1'b1) done_q.push_back(step_no);
   end

   // One strobe every 4 clocks; starts and ends 1 time unit after a rising edge.
   task automatic steps(input int n);
      repeat (n) begin
         step_in = 1'b1;
         @(posedge clk_in);
         #1 step_in = 1'b0;
         repeat (3) @(posedge clk_in);
         #1;
      end
   endtask

   int seq1[9] = '{8000, -16000, 16000, -16000, 16000, -16000, 16000, -8000, 0};
   int seq2[8] = '{8000, 16000, -16000, -16000, 16000, 16000, -16000, -8000};

   initial begin
      int nz;
      // reset state
      repeat (2) @(negedge clk_in);
      chk("rst_amp", amp_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_impulse", imp_a, 0);
      chk("rst_done", done_a, 0);
      @(posedge clk_in);
      #1 rst_in = 1'b1;

      // idle strobes without a request stay silent
      amp_log_a.delete();
      steps(5);
      nz = 0;
      foreach (amp_log_a[i]) if (amp_log_a[i] != 0) nz++;
      chk("idle_nonzero", nz, 0);
      chk("idle_no_impulse", imp_q.size(), 0);

      // burst sequences, stall mid-burst, request toggling ignored
      amp_log_a.delete(); amp_log_b.delete(); imp_q.delete(); done_q.delete();
      impulse_in = 1'b1;
      steps(1);
      impulse_in = 1'b0;
      steps(3);
      repeat (50) @(posedge clk_in);
      #1;
      chk("stall_hold", amp_a, -16000);
      chk("stall_busy", busy_a, 1);
      for (int i = 4; i < 80; i++) begin
         impulse_in = (i <= 60) ? i[0] : 1'b0;
         steps(1);
      end
      impulse_in = 1'b0;
      if (amp_log_a.size() >= 9 && amp_log_b.size() >= 8) begin
         for (int i = 0; i < 9; i++) chk("seq_hp1", amp_log_a[i], seq1[i]);
         for (int i = 0; i < 8; i++) chk("seq_hp2", amp_log_b[i], seq2[i]);
      end else begin
         chk("seq_log_len", amp_log_a.size(), 9);
      end
      chk("toggle_impulses", imp_q.size(), 1);
      chk("toggle_dones", done_q.size(), 1);
      if (imp_q.size() == 1 && done_q.size() == 1)
         chk("done_distance", done_q[0] - imp_q[0], 72);

      // held request: back-to-back bursts
      imp_q.delete(); done_q.delete();
      impulse_in = 1'b1;
      steps(150);
      impulse_in = 1'b0;
      if (imp_q.size() >= 2 && done_q.size() >= 1) begin
         chk("retrigger_distance", imp_q[1] - imp_q[0], 73);
         chk("done_between", done_q[0] - imp_q[0], 72);
      end else begin
         chk("retrigger_count", imp_q.size(), 2);
      end
      steps(80);

      // reset in the middle of a burst
      imp_q.delete(); done_q.delete();
      impulse_in = 1'b1;
      steps(1);
      impulse_in = 1'b0;
      steps(3);
      chk("pre_reset_amp", amp_a, -16000);
      #2 rst_in = 1'b0;
      #1;
      chk("reset_amp_now", amp_a, 0);
      chk("reset_busy_now", busy_a, 0);
      repeat (5) @(posedge clk_in);
      #1 rst_in = 1'b1;
      imp_q.delete(); amp_log_a.delete();
      steps(100);
      nz = 0;
      foreach (amp_log_a[i]) if (amp_log_a[i] != 0) nz++;
      chk("post_reset_silent", nz, 0);
      chk("post_reset_log_len", amp_log_a.size(), 100);
      chk("post_reset_no_done", done_q.size(), 0);
      chk("post_reset_no_impulse", imp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
